// File: rtl/bus_rr_mux.sv
// bus_rr_mux: N-way registered bus mux with round-robin arbitration and valid/ready output
module bus_rr_mux #(
    parameter int WIDTH = 16,
    parameter int N = 4,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*WIDTH-1:0] data,
    output logic [N-1:0]     gnt,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_src
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    src_q, src_d, ptr_q, ptr_d, win;
    logic             found, accept, take;
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win = SW'(idx);
            end
        end
    end
    assign accept = !reset && (!valid_q || out_ready);
    assign take = accept && found;
    assign gnt = take ? (N'(1) << win) : '0;
    always_comb begin
        out_d = take ? data[int'(win)*WIDTH +: WIDTH] : out_q;
        src_d = take ? win : src_q;
        ptr_d = take ? win : ptr_q;
        valid_d = accept ? found : valid_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            valid_q <= 1'b0;
            src_q <= '0;
            ptr_q <= SW'(N - 1);
        end else begin
            out_q <= out_d;
            valid_q <= valid_d;
            src_q <= src_d;
            ptr_q <= ptr_d;
        end
    end
    assign out = out_q;
    assign out_valid = valid_q;
    assign out_src = src_q;
endmodule

// File: tb/tb_bus_rr_mux.sv
// tb_bus_rr_mux: directed and random checks of bus_rr_mux against a distance-based round-robin model
module tb_bus_rr_mux;
    localparam int N = 4;
    localparam int W = 16;
    logic clk = 1'b0, reset, out_ready, out_valid;
    logic [N-1:0] req, gnt, g_seen;
    logic [N*W-1:0] data;
    logic [W-1:0] out, word;
    logic [1:0] out_src;
    int errors = 0, checks = 0;
    int mptr, msrc;
    logic [W-1:0] mout;
    logic mvalid;
    logic [3:0] seq [5];

    bus_rr_mux #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // winner is the requester closest after the pointer, measured as cyclic distance
    function automatic int pick(input logic [N-1:0] rq, input int p);
        int best = -1, bd = N;
        for (int i = 0; i < N; i++)
            if (rq[i] && ((i - p - 1 + 2 * N) % N) < bd) begin
                bd = (i - p - 1 + 2 * N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d, input logic rdy);
        logic acc;
        int w;
        logic [N-1:0] eg;
        reset = r; req = rq; data = d; out_ready = rdy;
        #1;
        acc = !r && (!mvalid || rdy);
        w = pick(rq, mptr);
        eg = (acc && w >= 0) ? N'(1) << w : '0;
        g_seen = gnt;
        chk("gnt", gnt, eg);
        @(posedge clk);
        if (r) begin
            mout = '0; mvalid = 1'b0; msrc = 0; mptr = N - 1;
        end else if (acc) begin
            if (w >= 0) begin
                mout = d[w*W +: W]; msrc = w; mvalid = 1'b1; mptr = w;
            end else mvalid = 1'b0;
        end
        #1;
        chk("out_valid", out_valid, mvalid);
        if (mvalid || r) begin
            chk("out", out, mout);
            chk("out_src", out_src, msrc);
        end
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        mptr = N - 1; msrc = 0; mout = '0; mvalid = 1'b0;
        reset = 1'b1; req = '0; data = '0; out_ready = 1'b0;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        repeat (2) step(1'b1, N'($urandom), rnd_data(), 1'($urandom));
        chk("t1_out", out, 16'h0);
        step(1'b0, 4'b0100, {16'h1111, 16'hA5A5, 16'h2222, 16'h3333}, 1'b1);
        chk("t2_gnt", g_seen, 4'b0100);
        chk("t2_out", out, 16'hA5A5);
        chk("t2_src", out_src, 2);
        step(1'b1, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, rnd_data(), 1'b1);
            chk("t3_gnt", g_seen, seq[i]);
            chk("t3_src", out_src, i % N);
        end
        word = out;
        repeat (3) begin
            step(1'b0, 4'b0011, rnd_data(), 1'b0);
            chk("t4_stall_gnt", g_seen, 4'b0000);
            chk("t4_frozen", out, word);
        end
        step(1'b0, 4'b0011, rnd_data(), 1'b1);
        chk("t4_resume", g_seen, 4'b0010);
        repeat (3) step(1'b0, 4'b1111, rnd_data(), 1'b1);
        step(1'b1, 4'b1111, rnd_data(), 1'b1);
        chk("t5_valid", out_valid, 1'b0);
        step(1'b0, 4'b0110, rnd_data(), 1'b1);
        chk("t5_first", g_seen, 4'b0010);
        step(1'b0, 4'b1010, rnd_data(), 1'b1);
        word = out;
        step(1'b0, 4'b0000, rnd_data(), 1'b1);
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_hold", out, word);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 31) == 0, N'($urandom), rnd_data(), $urandom_range(0, 3) != 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
